// File: rtl/max_pool_2.sv
// Second LeNet-5 max-pool layer: 2x2/stride-2 pooling of 16x10x10 conv-2 maps into 16x5x5 maps,
// with reads and writes going through the shared single-port result BRAM in 4-cycle slots.
module max_pool_2 #(
    parameter int DATA_SIZE = 16,
    parameter int DEPTH     = 16,
    parameter int IN_SIZE   = 10,
    parameter int OUT_SIZE  = 5,
    parameter int SRC_BASE  = 5880,
    parameter int DST_BASE  = 7480
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pool_2_en,
    input  logic [DATA_SIZE-1:0] result_bram_douta,
    output logic                 result_bram_ena,
    output logic                 result_bram_wea,
    output logic [12:0]          result_bram_addra,
    output logic [DATA_SIZE-1:0] result_bram_dina,
    output logic                 pool_2_finish
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(OUT_SIZE);

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        CHECK   = 6'b000010,
        LOAD    = 6'b000100,
        COMPARE = 6'b001000,
        STORE   = 6'b010000,
        DONE    = 6'b100000
    } state_t;

    state_t               state, state_d;
    logic [CW-1:0]        channel, channel_d;
    logic [PW-1:0]        row, row_d, col, col_d;
    logic [1:0]           k, k_d, circle, circle_d;
    logic [DATA_SIZE-1:0] max_val, max_d;
    logic                 ena_d, wea_d, finish_d;
    logic [12:0]          addra_d;
    logic [DATA_SIZE-1:0] dina_d;
    logic                 legal, run;

    always_comb begin
        legal = state inside {IDLE, CHECK, LOAD, COMPARE, STORE, DONE};
        // DONE must see a low enable to re-arm, and illegal codes must always recover
        run   = pool_2_en || (state == DONE) || !legal;

        state_d   = state;
        channel_d = channel;
        row_d     = row;
        col_d     = col;
        k_d       = k;
        circle_d  = circle;
        max_d     = max_val;
        ena_d     = result_bram_ena;
        wea_d     = result_bram_wea;
        addra_d   = result_bram_addra;
        dina_d    = result_bram_dina;
        finish_d  = pool_2_finish;

        if (run) begin
            case (state)
                IDLE: begin
                    channel_d = '0;
                    row_d     = '0;
                    col_d     = '0;
                    k_d       = '0;
                    circle_d  = '0;
                    finish_d  = 1'b0;
                    state_d   = CHECK;
                end
                CHECK: begin
                    // the write strobe from STORE is released here so a store spans four full cycles
                    ena_d = 1'b0;
                    wea_d = 1'b0;
                    if (channel == CW'(DEPTH)) begin
                        finish_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        k_d      = '0;
                        circle_d = '0;
                        state_d  = LOAD;
                    end
                end
                LOAD: begin
                    case (circle)
                        2'd0: begin
                            ena_d    = 1'b1;
                            wea_d    = 1'b0;
                            addra_d  = 13'(14'(SRC_BASE)
                                         + 14'(channel) * 14'(IN_SIZE * IN_SIZE)
                                         + (14'({row, 1'b0}) + 14'(k[1])) * 14'(IN_SIZE)
                                         + 14'({col, 1'b0}) + 14'(k[0]));
                            circle_d = 2'd1;
                        end
                        2'd3: begin
                            if (k == 2'd0 || $signed(result_bram_douta) > $signed(max_val))
                                max_d = result_bram_douta;
                            k_d      = k + 2'd1;
                            circle_d = 2'd0;
                            if (k == 2'd3) begin
                                ena_d   = 1'b0;
                                state_d = COMPARE;
                            end
                        end
                        default: circle_d = circle + 2'd1;
                    endcase
                end
                COMPARE: begin
                    dina_d   = max_val;
                    circle_d = '0;
                    state_d  = STORE;
                end
                STORE: begin
                    case (circle)
                        2'd0: begin
                            ena_d    = 1'b1;
                            wea_d    = 1'b1;
                            addra_d  = 13'(14'(DST_BASE)
                                         + 14'(channel) * 14'(OUT_SIZE * OUT_SIZE)
                                         + 14'(row) * 14'(OUT_SIZE)
                                         + 14'(col));
                            circle_d = 2'd1;
                        end
                        2'd3: begin
                            circle_d = '0;
                            state_d  = CHECK;
                            if (col == PW'(OUT_SIZE - 1)) begin
                                col_d = '0;
                                if (row == PW'(OUT_SIZE - 1)) begin
                                    row_d     = '0;
                                    channel_d = channel + CW'(1);
                                end else begin
                                    row_d = row + PW'(1);
                                end
                            end else begin
                                col_d = col + PW'(1);
                            end
                        end
                        default: circle_d = circle + 2'd1;
                    endcase
                end
                DONE: begin
                    if (!pool_2_en) begin
                        finish_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    ena_d   = 1'b0;
                    wea_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            channel           <= '0;
            row               <= '0;
            col               <= '0;
            k                 <= '0;
            circle            <= '0;
            max_val           <= '0;
            result_bram_ena   <= 1'b0;
            result_bram_wea   <= 1'b0;
            result_bram_addra <= '0;
            result_bram_dina  <= '0;
            pool_2_finish     <= 1'b0;
        end else begin
            state             <= state_d;
            channel           <= channel_d;
            row               <= row_d;
            col               <= col_d;
            k                 <= k_d;
            circle            <= circle_d;
            max_val           <= max_d;
            result_bram_ena   <= ena_d;
            result_bram_wea   <= wea_d;
            result_bram_addra <= addra_d;
            result_bram_dina  <= dina_d;
            pool_2_finish     <= finish_d;
        end
    end

endmodule

// File: tb/tb_max_pool_2.sv
// Directed bench for max_pool_2: BRAM model with optional X-outside-sample reads, protocol monitors,
// ramp image, signed compare, enable freeze, mid-run reset and completion handshake.
module tb_max_pool_2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pool_2_en;
    logic [15:0] douta;
    logic        ena, wea, finish;
    logic [12:0] addra;
    logic [15:0] dina;

    always #5 clk = ~clk;

    max_pool_2 #(
        .DATA_SIZE(16), .DEPTH(16), .IN_SIZE(10), .OUT_SIZE(5), .SRC_BASE(5880), .DST_BASE(7480)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pool_2_en(pool_2_en),
        .result_bram_douta(douta),
        .result_bram_ena(ena),
        .result_bram_wea(wea),
        .result_bram_addra(addra),
        .result_bram_dina(dina),
        .pool_2_finish(finish)
    );

    logic [15:0] mem [0:8191];
    int          wcount [0:399];
    int          rd_range_err, wr_range_err, x_err, age;
    logic        prev_rd, prev_wr, xmode;
    logic [12:0] prev_raddr, prev_waddr;
    logic        cmd_ramp, cmd_clear_out, cmd_clr_stats, poke_en;
    logic [12:0] poke_addr;
    logic [15:0] poke_data;

    int checks = 0;
    int failures = 0;
    int fe, act, viol;

    // Single owner of memory and monitor state; the initial block requests changes via cmd_* strobes.
    always @(posedge clk) begin
        if (cmd_ramp)
            for (int i = 0; i < 1600; i++) mem[5880 + i] <= 16'(i);
        if (cmd_clear_out)
            for (int i = 0; i < 400; i++) mem[7480 + i] <= '0;
        if (poke_en) mem[poke_addr] <= poke_data;
        if (cmd_clr_stats) begin
            for (int i = 0; i < 400; i++) wcount[i] <= 0;
            rd_range_err <= 0;
            wr_range_err <= 0;
            x_err        <= 0;
        end

        if (ena && wea) begin
            mem[addra] <= dina;
            if (!(prev_wr && prev_waddr == addra)) begin
                if (addra >= 13'd7480 && addra < 13'd7880)
                    wcount[addra - 13'd7480] <= wcount[addra - 13'd7480] + 1;
                else
                    wr_range_err <= wr_range_err + 1;
            end
            if ($isunknown(dina) || $isunknown(addra)) x_err <= x_err + 1;
        end
        prev_wr    <= ena && wea;
        prev_waddr <= addra;

        if (ena && !wea && !(addra >= 13'd5880 && addra < 13'd7480))
            rd_range_err <= rd_range_err + 1;
        if (xmode) begin
            if (ena && !wea && !(prev_rd && prev_raddr == addra)) begin
                age   <= 1;
                douta <= 'x;
            end else if (ena && !wea) begin
                age   <= age + 1;
                douta <= (age == 1) ? mem[addra] : 16'hxxxx;
            end else begin
                douta <= 'x;
            end
        end else if (ena && !wea) begin
            douta <= mem[addra];
        end
        prev_rd    <= ena && !wea;
        prev_raddr <= addra;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ramp_clear();
        cmd_ramp = 1'b1; cmd_clear_out = 1'b1; cmd_clr_stats = 1'b1;
        tick();
        cmd_ramp = 1'b0; cmd_clear_out = 1'b0; cmd_clr_stats = 1'b0;
    endtask

    task automatic poke(input logic [12:0] a, input logic [15:0] d);
        poke_addr = a; poke_data = d; poke_en = 1'b1;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic run_to_finish(input int budget, output int edge_at);
        edge_at = -1;
        for (int e = 1; e <= budget && edge_at < 0; e++) begin
            tick();
            if (finish === 1'b1) edge_at = e;
        end
    endtask

    task automatic check_ramp_image(input string tag);
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            int c = i / 25, r = (i % 25) / 5, q = i % 5;
            if (mem[7480 + i] !== 16'(c * 100 + (2 * r + 1) * 10 + 2 * q + 1)) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic check_writes_once(input string tag);
        int bad = 0;
        for (int i = 0; i < 400; i++) if (wcount[i] != 1) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        rst = 1'b1; pool_2_en = 1'b0; xmode = 1'b1;
        cmd_ramp = 1'b0; cmd_clear_out = 1'b0; cmd_clr_stats = 1'b0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        prev_rd = 1'b0; prev_wr = 1'b0; prev_raddr = '0; prev_waddr = '0; age = 0;
        tick();
        pulse_ramp_clear();
        tick();
        rst = 1'b0;
        tick();
        check("reset_ena", ena, 0);
        check("reset_wea", wea, 0);
        check("reset_finish", finish, 0);
        check("reset_addra", addra, 0);
        check("reset_dina", dina, 0);

        // Ramp run with the X-outside-sample BRAM model and first-output timing probes.
        pool_2_en = 1'b1;
        fe = -1;
        for (int e = 1; e <= 9000 && fe < 0; e++) begin
            tick();
            if (e == 3) begin
                check("first_read_ena", ena, 1);
                check("first_read_addr", addra, 5880);
            end
            if (e == 19) check("wea_low_e19", wea, 0);
            if (e == 20) begin
                check("wea_high_e20", wea, 1);
                check("first_write_addr", addra, 7480);
                check("first_write_data", dina, 11);
            end
            if (e == 23) check("wea_high_e23", wea, 1);
            if (e == 24) check("wea_low_e24", wea, 0);
            if (e == 25) check("second_read_addr", addra, 5882);
            if (finish === 1'b1) fe = e;
        end
        check("ramp_finish_edge", fe, 8802);
        check("ramp_addr7480", mem[7480], 11);
        check("ramp_addr7879", mem[7879], 1599);
        check_ramp_image("ramp_image");
        check_writes_once("ramp_write_once");
        check("read_range", rd_range_err, 0);
        check("write_range", wr_range_err, 0);
        check("x_capture", x_err, 0);

        // Completion handshake: stays done with no BRAM traffic, re-arms only through a low enable.
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (finish !== 1'b1 || ena !== 1'b0 || wea !== 1'b0) viol++;
        end
        check("done_hold", viol, 0);
        pool_2_en = 1'b0;
        tick();
        check("finish_fall", finish, 0);

        // Signed compare: mixed signs, then all negative, in channel 0 window (0,0).
        xmode = 1'b0;
        poke(13'd5880, 16'h8000);
        poke(13'd5881, 16'hFFFF);
        poke(13'd5890, 16'h7FFF);
        poke(13'd5891, 16'h0001);
        cmd_clear_out = 1'b1; cmd_clr_stats = 1'b1; tick(); cmd_clear_out = 1'b0; cmd_clr_stats = 1'b0;
        check("idle_finish_low", finish, 0);
        pool_2_en = 1'b1;
        run_to_finish(9000, fe);
        check("rerun_finish_edge", fe, 8802);
        check("signed_mixed", mem[7480], 16'h7FFF);
        check("signed_neighbor", mem[7481], 13);
        check_writes_once("rerun_write_once");
        pool_2_en = 1'b0;
        tick();
        poke(13'd5880, 16'h8000);
        poke(13'd5881, 16'hFFFE);
        poke(13'd5890, 16'hFFFF);
        poke(13'd5891, 16'h8001);
        pool_2_en = 1'b1;
        run_to_finish(9000, fe);
        check("neg_finish_edge", fe, 8802);
        check("signed_all_neg", mem[7480], 16'hFFFF);

        // Enable freeze at circle 1 of the first read and inside the first store slot.
        pool_2_en = 1'b0;
        tick();
        pulse_ramp_clear();
        pool_2_en = 1'b1;
        act = 0;
        fe = -1;
        while (act < 9000 && fe < 0) begin
            tick();
            act++;
            if (act == 3 || act == 21) begin
                pool_2_en = 1'b0;
                viol = 0;
                for (int i = 0; i < 7; i++) begin
                    tick();
                    if (act == 3 && (ena !== 1'b1 || wea !== 1'b0 || addra !== 13'd5880)) viol++;
                    if (act == 21 && (ena !== 1'b1 || wea !== 1'b1 || addra !== 13'd7480 || dina !== 16'd11))
                        viol++;
                end
                check(act == 3 ? "freeze_read" : "freeze_store", viol, 0);
                pool_2_en = 1'b1;
            end
            if (finish === 1'b1) fe = act;
        end
        check("freeze_finish_edge", fe, 8802);
        check_ramp_image("freeze_image");
        check_writes_once("freeze_write_once");

        // Reset during LOAD of output 37, then a clean rerun from (0,0,0).
        pool_2_en = 1'b0;
        tick();
        pulse_ramp_clear();
        pool_2_en = 1'b1;
        for (int i = 0; i < 820; i++) tick();
        check("pre_reset_ena", ena, 1);
        rst = 1'b1; pool_2_en = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_reset_ena", ena, 0);
        check("mid_reset_wea", wea, 0);
        check("mid_reset_finish", finish, 0);
        cmd_clear_out = 1'b1; cmd_clr_stats = 1'b1; tick(); cmd_clear_out = 1'b0; cmd_clr_stats = 1'b0;
        pool_2_en = 1'b1;
        tick(); tick(); tick();
        check("rerun_first_addr", addra, 5880);
        run_to_finish(9000, fe);
        check("reset_rerun_finish_edge", fe + 3, 8802);
        check_ramp_image("reset_rerun_image");
        check_writes_once("reset_rerun_write_once");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
